// File: rtl/obi_init_pkg.sv
// Shared types for the OBI data initiator.
// OBI_INIT_LOAD_ALIGN_EN adds load alignment metadata.
package obi_init_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic       we;
`ifdef OBI_INIT_LOAD_ALIGN_EN
    size_e      size;
    logic       sgn;
    logic [1:0] off;
`endif
  } rsp_meta_t;

  function automatic logic [3:0] be_gen(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// Response metadata FIFO: circular buffer with
// wrap bits on both pointers to tell full from empty.
module obi_rsp_fifo
  import obi_init_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW:0]      wr_q, wr_d;
  logic [IW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  function automatic logic [IW:0] ptr_nxt(input logic [IW:0] p);
    logic [IW:0] n;
    if (p[IW-1:0] == IW'(DEPTH - 1)) begin
      n = {~p[IW], {IW{1'b0}}};
    end else begin
      n = p + (IW+1)'(1);
    end
    return n;
  endfunction

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = ptr_nxt(wr_q);
    if (pop_i)  rd_d = ptr_nxt(rd_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_i) mem_q[wr_q[IW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_q[IW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[IW-1:0] == rd_q[IW-1:0]) &&
                   (wr_q[IW] != rd_q[IW]);

endmodule

// File: rtl/obi_data_initiator.sv
// OBI req/gnt/rvalid data initiator with in-order tagged responses.
// Optional load align/extend: define OBI_INIT_LOAD_ALIGN_EN.
module obi_data_initiator
  import obi_init_pkg::*;
#(
  parameter  int unsigned MAX_OUTSTANDING = 4,
  parameter  int unsigned TAG_W           = 4,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_addr_i,
  input  logic             cmd_we_i,
  input  logic [1:0]       cmd_size_i,
  input  logic             cmd_signed_i,
  input  logic [31:0]      cmd_wdata_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic             data_req_o,
  output logic [31:0]      data_addr_o,
  output logic             data_we_o,
  output logic [31:0]      data_wdata_o,
  output logic [3:0]       data_be_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  input  logic [31:0]      data_rdata_i,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_rdata_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_we_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             proto_err_o
);

  localparam int unsigned ENT_W = TAG_W + $bits(rsp_meta_t);

  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  rsp_meta_t        meta_q, meta_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             live_q;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_we_q, rsp_we_d;

  logic             accept;
  logic             grant;
  logic             pop;
  logic             fifo_empty;
  logic             unused_full;
  logic [ENT_W-1:0] fifo_rdata;
  logic [TAG_W-1:0] pop_tag;
  rsp_meta_t        pop_meta;
  logic [CNT_W:0]   inflight;
  logic [31:0]      load_data;

  // live_q keeps ready low while in reset so every output reads 0
  assign inflight    = {1'b0, cnt_q} + (CNT_W+1)'(req_q);
  assign cmd_ready_o = live_q & (~req_q | data_gnt_i) &
                       (inflight < (CNT_W+1)'(MAX_OUTSTANDING));
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign grant       = req_q & data_gnt_i;
  assign pop         = data_rvalid_i & ~fifo_empty;
  assign {pop_tag, pop_meta} = fifo_rdata;

  obi_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .wdata_i ({tag_q, meta_q}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (unused_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    meta_d  = meta_q;
    if (grant) req_d = 1'b0;
    if (accept) begin
      req_d     = 1'b1;
      addr_d    = {cmd_addr_i[31:2], 2'b00};
      we_d      = cmd_we_i;
      be_d      = be_gen(cmd_size_i, cmd_addr_i[1:0]);
      wdata_d   = cmd_wdata_i << {cmd_addr_i[1:0], 3'b000};
      tag_d     = cmd_tag_i;
      meta_d.we = cmd_we_i;
`ifdef OBI_INIT_LOAD_ALIGN_EN
      meta_d.size = size_e'(cmd_size_i);
      meta_d.sgn  = cmd_signed_i;
      meta_d.off  = cmd_addr_i[1:0];
`endif
    end
  end

`ifdef OBI_INIT_LOAD_ALIGN_EN
  logic [31:0] sh;
  always_comb begin
    sh        = data_rdata_i >> {pop_meta.off, 3'b000};
    load_data = sh;
    case (pop_meta.size)
      SZ_BYTE: load_data = {{24{pop_meta.sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: load_data = {{16{pop_meta.sgn & sh[15]}}, sh[15:0]};
      default: load_data = sh;
    endcase
    if (pop_meta.we) load_data = data_rdata_i;
  end
`else
  logic unused_sgn;
  assign unused_sgn = cmd_signed_i;
  assign load_data  = data_rdata_i;
`endif

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(grant) - CNT_W'(pop);
    err_d       = err_q | (data_rvalid_i & fifo_empty);
    rsp_valid_d = pop;
    rsp_rdata_d = rsp_rdata_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_we_d    = rsp_we_q;
    if (pop) begin
      rsp_rdata_d = load_data;
      rsp_tag_d   = pop_tag;
      rsp_we_d    = pop_meta.we;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      meta_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      live_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_tag_q   <= '0;
      rsp_we_q    <= 1'b0;
    end else begin
      req_q       <= req_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      tag_q       <= tag_d;
      meta_q      <= meta_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      live_q      <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  assign data_req_o    = req_q;
  assign data_addr_o   = addr_q;
  assign data_we_o     = we_q;
  assign data_be_o     = be_q;
  assign data_wdata_o  = wdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_tag_o     = rsp_tag_q;
  assign rsp_we_o      = rsp_we_q;
  assign outstanding_o = cnt_q;
  assign proto_err_o   = err_q;

endmodule
